// File: rtl/mem_wb_buf.sv
// mem_wb_buf: two-entry skid buffer between the mem and wb stages,
// with a forwarding tap on the head entry and a 64-bit retire counter.
// Revision: 1.0
`default_nettype none

module mem_wb_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic              in_rd_wr_en_i,
  input  logic [REG_AW-1:0] in_rd_addr_i,
  input  logic [DATA_W-1:0] in_rd_data_i,
  input  logic              in_csr_wr_en_i,
  input  logic [CSR_AW-1:0] in_csr_addr_i,
  input  logic [DATA_W-1:0] in_csr_wdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              out_rd_wr_en_o,
  output logic [REG_AW-1:0] out_rd_addr_o,
  output logic [DATA_W-1:0] out_rd_data_o,
  output logic              out_csr_wr_en_o,
  output logic [CSR_AW-1:0] out_csr_addr_o,
  output logic [DATA_W-1:0] out_csr_wdata_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_rd_addr_o,
  output logic [DATA_W-1:0] fwd_rd_data_o,
  output logic [63:0]       retired_cnt_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              rd_wr_en;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              csr_wr_en;
    logic [CSR_AW-1:0] csr_addr;
    logic [DATA_W-1:0] csr_wdata;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  entry_t      slot0_q, slot0_d;
  entry_t      slot1_q, slot1_d;
  logic        in_ready_q, in_ready_d;
  logic [63:0] retired_cnt_q, retired_cnt_d;

  logic   accept;
  logic   pop;
  logic   out_valid;
  entry_t in_entry;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid_i & in_ready_q;
  assign pop       = out_valid & out_ready_i;

  // x0 writes are squashed at capture so wb and forwarding never see them.
  always_comb begin
    in_entry.pc        = in_pc_i;
    in_entry.rd_wr_en  = in_rd_wr_en_i & (in_rd_addr_i != '0);
    in_entry.rd_addr   = in_rd_addr_i;
    in_entry.rd_data   = in_rd_data_i;
    in_entry.csr_wr_en = in_csr_wr_en_i;
    in_entry.csr_addr  = in_csr_addr_i;
    in_entry.csr_wdata = in_csr_wdata_i;
  end

  always_comb begin
    state_d       = state_q;
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    retired_cnt_d = retired_cnt_q + {63'd0, pop};

    if (flush_i) begin
      state_d           = ST_EMPTY;
      slot0_d.rd_wr_en  = 1'b0;
      slot0_d.csr_wr_en = 1'b0;
      slot1_d.rd_wr_en  = 1'b0;
      slot1_d.csr_wr_en = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            slot0_d = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            slot0_d = in_entry;
          end else if (accept) begin
            slot1_d = in_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            slot0_d = slot1_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      slot0_q       <= '0;
      slot1_q       <= '0;
      in_ready_q    <= 1'b1;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      slot0_q       <= slot0_d;
      slot1_q       <= slot1_d;
      in_ready_q    <= in_ready_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid;
  assign out_pc_o        = slot0_q.pc;
  assign out_rd_wr_en_o  = slot0_q.rd_wr_en;
  assign out_rd_addr_o   = slot0_q.rd_addr;
  assign out_rd_data_o   = slot0_q.rd_data;
  assign out_csr_wr_en_o = slot0_q.csr_wr_en;
  assign out_csr_addr_o  = slot0_q.csr_addr;
  assign out_csr_wdata_o = slot0_q.csr_wdata;
  assign fwd_valid_o     = out_valid & slot0_q.rd_wr_en;
  assign fwd_rd_addr_o   = slot0_q.rd_addr;
  assign fwd_rd_data_o   = fwd_valid_o ? slot0_q.rd_data : '0;
  assign retired_cnt_o   = retired_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_buf.sv
// tb_mem_wb_buf: directed and randomized checks of mem_wb_buf against a
// queue-based reference model.
`default_nettype none

module tb_mem_wb_buf;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] in_pc_i, in_rd_data_i, in_csr_wdata_i;
  logic        in_rd_wr_en_i, in_csr_wr_en_i;
  logic [4:0]  in_rd_addr_i;
  logic [11:0] in_csr_addr_i;
  logic [31:0] out_pc_o, out_rd_data_o, out_csr_wdata_o, fwd_rd_data_o;
  logic        out_rd_wr_en_o, out_csr_wr_en_o, fwd_valid_o;
  logic [4:0]  out_rd_addr_o, fwd_rd_addr_o;
  logic [11:0] out_csr_addr_o;
  logic [63:0] retired_cnt_o;

  always #5 clk = ~clk;

  mem_wb_buf dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
    .in_rd_wr_en_i(in_rd_wr_en_i), .in_rd_addr_i(in_rd_addr_i),
    .in_rd_data_i(in_rd_data_i), .in_csr_wr_en_i(in_csr_wr_en_i),
    .in_csr_addr_i(in_csr_addr_i), .in_csr_wdata_i(in_csr_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_rd_wr_en_o(out_rd_wr_en_o), .out_rd_addr_o(out_rd_addr_o),
    .out_rd_data_o(out_rd_data_o), .out_csr_wr_en_o(out_csr_wr_en_o),
    .out_csr_addr_o(out_csr_addr_o), .out_csr_wdata_o(out_csr_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_addr_o(fwd_rd_addr_o),
    .fwd_rd_data_o(fwd_rd_data_o), .retired_cnt_o(retired_cnt_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } ent_t;

  // Reference model: an in-order queue of at most two results.
  ent_t        mq[$];
  logic [63:0] mcnt = 64'd0;
  int          preload_tok = 0;
  int          seen_tok = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   do_pop, do_acc;
    if (preload_tok != seen_tok) begin
      mcnt     = 64'hFFFF_FFFF_FFFF_FFFF;
      seen_tok = preload_tok;
    end
    if (rst) begin
      mq.delete();
      mcnt = 64'd0;
    end else begin
      do_pop = (mq.size() > 0) && out_ready_i;
      do_acc = in_valid_i && (mq.size() < 2);
      if (do_pop) mcnt = mcnt + 64'd1;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_acc) begin
          e.pc        = in_pc_i;
          e.rd_en     = in_rd_wr_en_i && (in_rd_addr_i != 5'd0);
          e.rd_addr   = in_rd_addr_i;
          e.rd_data   = in_rd_data_i;
          e.csr_en    = in_csr_wr_en_i;
          e.csr_addr  = in_csr_addr_i;
          e.csr_wdata = in_csr_wdata_i;
          mq.push_back(e);
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit          hv;
    bit          fv;
    logic [31:0] fd;
    hv = (mq.size() > 0);
    fv = hv && mq[0].rd_en;
    fd = fv ? mq[0].rd_data : 32'd0;
    check("out_valid", {63'd0, out_valid_o}, {63'd0, hv});
    check("in_ready", {63'd0, in_ready_o}, {63'd0, mq.size() != 2});
    check("fwd_valid", {63'd0, fwd_valid_o}, {63'd0, fv});
    check("fwd_rd_data", {32'd0, fwd_rd_data_o}, {32'd0, fd});
    check("retired_cnt", retired_cnt_o, mcnt);
    if (hv) begin
      check("out_pc", {32'd0, out_pc_o}, {32'd0, mq[0].pc});
      check("out_rd_wr_en", {63'd0, out_rd_wr_en_o}, {63'd0, mq[0].rd_en});
      check("out_rd_addr", {59'd0, out_rd_addr_o}, {59'd0, mq[0].rd_addr});
      check("out_rd_data", {32'd0, out_rd_data_o}, {32'd0, mq[0].rd_data});
      check("out_csr_wr_en", {63'd0, out_csr_wr_en_o}, {63'd0, mq[0].csr_en});
      check("out_csr_addr", {52'd0, out_csr_addr_o}, {52'd0, mq[0].csr_addr});
      check("out_csr_wdata", {32'd0, out_csr_wdata_o}, {32'd0, mq[0].csr_wdata});
      if (fv) check("fwd_rd_addr", {59'd0, fwd_rd_addr_o}, {59'd0, mq[0].rd_addr});
    end
  endtask

  // One clock: the edge happens, then outputs are compared on the falling edge.
  task automatic cyc();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] data);
    in_valid_i     = v;
    in_pc_i        = pc;
    in_rd_wr_en_i  = 1'b1;
    in_rd_addr_i   = rd;
    in_rd_data_i   = data;
    in_csr_wr_en_i = pc[2];
    in_csr_addr_i  = pc[13:2];
    in_csr_wdata_i = ~data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    cyc(); cyc();
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    check("rst_cnt", retired_cnt_o, 64'd0);
    check("rst_rd_data", {32'd0, out_rd_data_o}, 64'd0);
    rst = 1'b0;

    // Single accept, then pop.
    drive(1'b1, 32'h100, 5'd5, 32'hDEADBEEF); out_ready_i = 1'b1;
    cyc();
    check("t1_valid", {63'd0, out_valid_o}, 64'd1);
    check("t1_pc", {32'd0, out_pc_o}, 64'h100);
    check("t1_rd", {59'd0, out_rd_addr_o}, 64'd5);
    check("t1_data", {32'd0, out_rd_data_o}, 64'hDEADBEEF);
    check("t1_fwd", {63'd0, fwd_valid_o}, 64'd1);
    in_valid_i = 1'b0;
    cyc();
    check("t1_cnt", retired_cnt_o, 64'd1);

    // Back-pressure: two stored, third stalled, then drain in order.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h100, 5'd1, 32'h11); cyc();
    drive(1'b1, 32'h104, 5'd2, 32'h22); cyc();
    check("t2_not_ready", {63'd0, in_ready_o}, 64'd0);
    drive(1'b1, 32'h108, 5'd3, 32'h33); cyc();
    check("t2_head_held", {32'd0, out_pc_o}, 64'h100);
    out_ready_i = 1'b1; cyc();
    check("t2_head2", {32'd0, out_pc_o}, 64'h104);
    cyc();
    check("t2_head3", {32'd0, out_pc_o}, 64'h108);
    in_valid_i = 1'b0; cyc();
    check("t2_cnt", retired_cnt_o, 64'd4);

    // x0 write squashed.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h200, 5'd0, 32'h1234); cyc();
    check("t3_valid", {63'd0, out_valid_o}, 64'd1);
    check("t3_rd_en", {63'd0, out_rd_wr_en_o}, 64'd0);
    check("t3_fwd", {63'd0, fwd_valid_o}, 64'd0);
    in_valid_i = 1'b0; out_ready_i = 1'b1; cyc();

    // Flush while full with a concurrent accept attempt and pop.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h300, 5'd7, 32'h77); cyc();
    drive(1'b1, 32'h304, 5'd8, 32'h88); cyc();
    check("t4_full", {63'd0, in_ready_o}, 64'd0);
    flush_i = 1'b1; out_ready_i = 1'b1;
    drive(1'b1, 32'h308, 5'd9, 32'h99); cyc();
    check("t4_valid", {63'd0, out_valid_o}, 64'd0);
    check("t4_ready", {63'd0, in_ready_o}, 64'd1);
    check("t4_cnt", retired_cnt_o, 64'd6);
    check("t4_rd_en", {63'd0, out_rd_wr_en_o}, 64'd0);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;

    // Counter wrap.
    drive(1'b1, 32'h400, 5'd4, 32'h44); cyc();
    in_valid_i = 1'b0;
    force dut.retired_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.retired_cnt_q;
    preload_tok = preload_tok + 1;
    check("t5_preload", retired_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready_i = 1'b1; cyc();
    check("t5_wrap", retired_cnt_o, 64'd0);

    // Reset while full.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h500, 5'd10, 32'hAAAA); cyc();
    drive(1'b1, 32'h504, 5'd11, 32'hBBBB); cyc();
    out_ready_i = 1'b1; cyc();
    rst = 1'b1; in_valid_i = 1'b0; cyc();
    check("t6_valid", {63'd0, out_valid_o}, 64'd0);
    check("t6_cnt", retired_cnt_o, 64'd0);
    check("t6_rd_data", {32'd0, out_rd_data_o}, 64'd0);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(1'($urandom), $urandom, rd, $urandom);
      in_rd_wr_en_i  = 1'($urandom);
      in_csr_wr_en_i = 1'($urandom);
      out_ready_i    = ($urandom_range(0, 2) != 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_buf.md
Name: mem_wb_buf

Overview:
- Pipeline buffer between the mem stage and the wb stage.
- Captures mem results (GPR write, CSR write, PC) into a 2-entry skid buffer using a valid/ready handshake, so wb back-pressure never drops a mem result.
- Provides a forwarding tap for the oldest pending GPR write.
- Maintains a 64-bit retired-instruction counter, intended as the source for minstret.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, GPR/CSR data width
- REG_AW, 5, GPR address width
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  drop all buffered entries (trap/branch redirect)
- in_valid_i  in  1  mem presents a result this cycle
- in_ready_o  out  1  buffer can accept
- in_pc_i  in  ADDR_W  PC of the instruction
- in_rd_wr_en_i  in  1  GPR write request
- in_rd_addr_i  in  REG_AW  GPR destination
- in_rd_data_i  in  DATA_W  GPR write data
- in_csr_wr_en_i  in  1  CSR write request
- in_csr_addr_i  in  CSR_AW  CSR address
- in_csr_wdata_i  in  DATA_W  CSR write data
- out_valid_o  out  1  head entry valid toward wb
- out_ready_i  in  1  wb consumes head
- out_pc_o  out  ADDR_W  head PC
- out_rd_wr_en_o  out  1  head GPR write enable, already gated for x0
- out_rd_addr_o  out  REG_AW  head GPR address
- out_rd_data_o  out  DATA_W  head GPR data
- out_csr_wr_en_o  out  1  head CSR write enable
- out_csr_addr_o  out  CSR_AW  head CSR address
- out_csr_wdata_o  out  DATA_W  head CSR data
- fwd_valid_o  out  1  head holds a live GPR write
- fwd_rd_addr_o  out  REG_AW  forwarding address
- fwd_rd_data_o  out  DATA_W  forwarding data
- retired_cnt_o  out  64  count of entries consumed by wb

Behaviour:
Storage and handshake
- Two entries, slot0 = head and slot1 = skid. State: EMPTY / ONE / FULL.
- in_ready_o = (state != FULL). It is registered, depending only on state, with no combinational path from out_ready_i.
- Accept = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.

Transitions
- EMPTY: accept → ONE (write slot0).
- ONE:
  - accept & pop → ONE (slot0 ← input)
  - accept only → FULL (slot1 ← input)
  - pop only → EMPTY
- FULL: accept is impossible.
  - pop → ONE (slot0 ← slot1)
  - no pop → hold.

Latency and outputs
- Latency is 1 cycle: data accepted at edge N is visible on out_* after edge N.
- out_valid_o = (state != EMPTY).
- All out_* fields are driven directly from slot0 registers.

x0 handling
- An entry captured with in_rd_wr_en_i=1 and in_rd_addr_i=0 is stored with rd_wr_en=0.

Forwarding
- fwd_valid_o = out_valid_o & slot0.rd_wr_en.
- fwd_rd_addr_o / fwd_rd_data_o = slot0 fields.
- When fwd_valid_o=0, fwd_rd_data_o is 0.

Flush
- flush_i → state EMPTY next cycle, and every entry's enables are cleared.
- An accept in the same cycle as flush_i is discarded.
- A pop in the same cycle as flush_i still counts as retired.
- in_ready_o is 1 in the cycle after a flush.

Retire counter
- retired_cnt_o += 1 on each pop.
- It wraps from 2^64-1 to 0.
- It is unaffected by flush.

Reset
- state EMPTY.
- All slot fields are 0.
- out_valid_o=0, in_ready_o=1, fwd_valid_o=0, retired_cnt_o=0.
- All out_* data outputs are 0.
- rst overrides flush_i and any handshake.
- Mid-operation reset discards buffered entries without counting them.

Test Plan:
1. Reset, then one accept (pc=0x100, rd=5, data=0xDEADBEEF) with out_ready_i=1 → out_valid_o=1 next cycle with those values; retired_cnt_o=1 after the pop edge.
2. Hold out_ready_i=0 and push 3 back-to-back entries → first two stored, in_ready_o=0 after the 2nd, 3rd not accepted; on release, entries drain in order pc 0x100, 0x104, then the 3rd is accepted.
3. Accept rd=0 with rd_wr_en=1, data=0x1234 → out_rd_wr_en_o=0 and fwd_valid_o=0.
4. Buffer FULL, assert flush_i together with in_valid_i and out_ready_i → next cycle out_valid_o=0, in_ready_o=1, retired_cnt_o incremented by exactly 1.
5. Preload retired counter near wrap (force 0xFFFF_FFFF_FFFF_FFFF) and pop once → retired_cnt_o=0.
6. Assert rst while FULL → next cycle out_valid_o=0, retired_cnt_o=0, out_rd_data_o=0.
